// File: rtl/ex_mem_skid_reg_if.sv
// -----------------------------------------------------------------------------
// ex_mem_skid_reg_if
// One pipeline-stage link: a valid/ready handshake plus the EX/MEM payload.
// The same interface type is used on both sides of ex_mem_skid_reg: the EX side
// connects through the slave modport, the MEM side through the master modport.
//
// Signals
//   valid      producer presents an entry
//   ready      consumer can take the entry this cycle
//   result     shifter/ALU result (also the load/store address), DW bits
//   storeData  rt value for stores, DW bits
//   rd         destination register index, RW bits
//   regWrite   entry writes the register file
//   memRead    entry is a load
//   memWrite   entry is a store
//
// Modports
//   master  drives valid and payload, samples ready
//   slave   samples valid and payload, drives ready
// -----------------------------------------------------------------------------
interface ex_mem_skid_reg_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic          valid;
   logic          ready;
   logic [DW-1:0] result;
   logic [DW-1:0] storeData;
   logic [RW-1:0] rd;
   logic          regWrite;
   logic          memRead;
   logic          memWrite;

   modport master (
      output valid,
      output result,
      output storeData,
      output rd,
      output regWrite,
      output memRead,
      output memWrite,
      input  ready
   );

   modport slave (
      input  valid,
      input  result,
      input  storeData,
      input  rd,
      input  regWrite,
      input  memRead,
      input  memWrite,
      output ready
   );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// -----------------------------------------------------------------------------
// ex_mem_skid_reg
// EX/MEM pipeline boundary register built as a two-entry skid buffer. The
// upstream ready is a flop (high whenever the skid slot is empty), so MEM-side
// back-pressure never forms a combinational path back into the EX datapath.
// The main register drives the MEM-side outputs directly; the skid register
// catches the one entry that may arrive while MEM is stalling.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset, clears every entry
//   flush           synchronous flush, drops all buffered entries
//   exSide          slave link from EX (valid/ready + payload)
//   memSide         master link to MEM (valid/ready + payload)
//   perf_stall_cnt  cycles with memSide.valid=1 and memSide.ready=0
//
// Build option
//   EX_MEM_PERF_EN  when defined, perf_stall_cnt is a saturating 32-bit stall
//                   counter cleared only by reset; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module ex_mem_skid_reg #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   ex_mem_skid_reg_if.slave     exSide,
   ex_mem_skid_reg_if.master    memSide,
   output logic [31:0]          perf_stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,   // main invalid
      ONE   = 2'd1,   // main valid, skid invalid
      FULL  = 2'd2    // main and skid valid
   } state_t;

   typedef struct packed {
      logic [DW-1:0] result;
      logic [DW-1:0] storeData;
      logic [RW-1:0] rd;
      logic          regWrite;
      logic          memRead;
      logic          memWrite;
   } entry_t;

   localparam int EW = $bits(entry_t);

   state_t stateR;
   state_t stateNxt;
   entry_t mainR;
   entry_t skidR;
   entry_t captured;
   logic   memValidR;
   logic   exReadyR;
   logic   accept;
   logic   retire;
   logic   loadMain;
   logic   loadSkid;
   logic   promoteSkid;

   // Handshake qualifiers; ready is the registered flag, so accept is safe in FULL.
   assign accept = exSide.valid && exReadyR;
   assign retire = memValidR && memSide.ready;

   // Capture the incoming entry; a write to register 0 is never a real write.
   always_comb begin
      captured.result    = exSide.result;
      captured.storeData = exSide.storeData;
      captured.rd        = exSide.rd;
      captured.regWrite  = exSide.regWrite && (exSide.rd != {RW{1'b0}});
      captured.memRead   = exSide.memRead;
      captured.memWrite  = exSide.memWrite;
   end

   // Next-state and load-enable decode; flush overrides every other transition.
   always_comb begin
      stateNxt    = stateR;
      loadMain    = 1'b0;
      loadSkid    = 1'b0;
      promoteSkid = 1'b0;
      if (flush) begin
         stateNxt = EMPTY;
      end else begin
         case (stateR)
            EMPTY: begin
               if (accept) begin
                  loadMain = 1'b1;
                  stateNxt = ONE;
               end else begin
                  stateNxt = EMPTY;
               end
            end
            ONE: begin
               if (accept && retire) begin
                  // main is consumed and refilled in the same edge
                  loadMain = 1'b1;
                  stateNxt = ONE;
               end else if (accept) begin
                  loadSkid = 1'b1;
                  stateNxt = FULL;
               end else if (retire) begin
                  stateNxt = EMPTY;
               end else begin
                  stateNxt = ONE;
               end
            end
            FULL: begin
               if (retire) begin
                  promoteSkid = 1'b1;
                  stateNxt    = ONE;
               end else begin
                  stateNxt = FULL;
               end
            end
            default: begin
               stateNxt = EMPTY;
            end
         endcase
      end
   end

   // State and handshake flags; ready/valid are registered copies of the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateR    <= EMPTY;
         memValidR <= 1'b0;
         exReadyR  <= 1'b1;
      end else begin
         stateR    <= stateNxt;
         memValidR <= (stateNxt != EMPTY);
         exReadyR  <= (stateNxt != FULL);
      end
   end

   // Payload registers; flush leaves the data in place since the valids are cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainR <= {EW{1'b0}};
         skidR <= {EW{1'b0}};
      end else begin
         if (loadMain) begin
            mainR <= captured;
         end else if (promoteSkid) begin
            mainR <= skidR;
         end else begin
            mainR <= mainR;
         end
         if (loadSkid) begin
            skidR <= captured;
         end else begin
            skidR <= skidR;
         end
      end
   end

   assign exSide.ready      = exReadyR;
   assign memSide.valid     = memValidR;
   assign memSide.result    = mainR.result;
   assign memSide.storeData = mainR.storeData;
   assign memSide.rd        = mainR.rd;
   assign memSide.regWrite  = mainR.regWrite;
   assign memSide.memRead   = mainR.memRead;
   assign memSide.memWrite  = mainR.memWrite;

`ifdef EX_MEM_PERF_EN
   logic [31:0] stallCntR;

   // Saturating back-pressure counter; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCntR <= 32'h0000_0000;
      end else if (memValidR && !memSide.ready && (stallCntR != 32'hFFFF_FFFF)) begin
         stallCntR <= stallCntR + 32'd1;
      end else begin
         stallCntR <= stallCntR;
      end
   end

   assign perf_stall_cnt = stallCntR;
`else
   assign perf_stall_cnt = 32'h0000_0000;
`endif

endmodule
